// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: IR fields, ALU flag and datapath control bundle; mem_ready exists under MCCTRL_MEMWAIT_EN.
interface multicycle_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
`ifdef MCCTRL_MEMWAIT_EN
    logic       mem_ready;
`endif
    logic       pc_en;
    logic       ir_write;
    logic       iord;
    logic       mem_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       zero_ext;
    logic [1:0] pc_src;
    logic [2:0] alu_control;
    logic [3:0] state;
    logic       illegal;

    modport master (
`ifdef MCCTRL_MEMWAIT_EN
        input  mem_ready,
`endif
        input  op, funct, zero,
        output pc_en, ir_write, iord, mem_write, reg_write, mem_to_reg, reg_dst,
        output alu_src_a, alu_src_b, zero_ext, pc_src, alu_control, state, illegal
    );

    modport slave (
`ifdef MCCTRL_MEMWAIT_EN
        output mem_ready,
`endif
        output op, funct, zero,
        input  pc_en, ir_write, iord, mem_write, reg_write, mem_to_reg, reg_dst,
        input  alu_src_a, alu_src_b, zero_ext, pc_src, alu_control, state, illegal
    );
endinterface

// File: rtl/multicycle_controller.sv
// multicycle_controller: MIPS-style multicycle control FSM.
// Define MCCTRL_MEMWAIT_EN to stall FETCH/MEMRD/MEMWR on mem_ready.
module multicycle_controller (
    input  logic                    clk,
    input  logic                    rst,
    multicycle_controller_if.master m
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXEC    = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEXEC = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t state_q, nxt, cur;
    logic   ready;

`ifdef MCCTRL_MEMWAIT_EN
    assign ready = m.mem_ready;
`else
    assign ready = 1'b1;
`endif

    // Reset forces the decode to FETCH so selects are defined before the first edge.
    assign cur     = rst ? FETCH : state_q;
    assign m.state = state_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= FETCH;
        else     state_q <= nxt;
    end

    always_comb begin
        nxt           = FETCH;
        m.pc_en       = 1'b0;
        m.ir_write    = 1'b0;
        m.iord        = 1'b0;
        m.mem_write   = 1'b0;
        m.reg_write   = 1'b0;
        m.mem_to_reg  = 1'b0;
        m.reg_dst     = 1'b0;
        m.alu_src_a   = 1'b0;
        m.alu_src_b   = 2'b00;
        m.zero_ext    = 1'b0;
        m.pc_src      = 2'b00;
        m.alu_control = 3'b000;
        m.illegal     = 1'b0;
        case (cur)
            FETCH: begin
                m.alu_src_b   = 2'b01;
                m.alu_control = 3'b010;
                m.ir_write    = ready;
                m.pc_en       = ready;
                nxt           = ready ? DECODE : FETCH;
            end
            DECODE: begin
                m.alu_src_b   = 2'b11;
                m.alu_control = 3'b010;
                case (m.op)
                    OP_LW, OP_SW:           nxt = MEMADR;
                    OP_RTYPE:               nxt = EXEC;
                    OP_BEQ:                 nxt = BRANCH;
                    OP_ADDI, OP_ORI, OP_LUI: nxt = IMMEXEC;
                    OP_J:                   nxt = JUMP;
                    default:                m.illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                m.alu_src_a   = 1'b1;
                m.alu_src_b   = 2'b10;
                m.alu_control = 3'b010;
                nxt           = (m.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                m.iord = 1'b1;
                nxt    = ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                m.reg_write  = 1'b1;
                m.mem_to_reg = 1'b1;
            end
            MEMWR: begin
                m.iord      = 1'b1;
                m.mem_write = 1'b1;
                nxt         = ready ? FETCH : MEMWR;
            end
            EXEC: begin
                m.alu_src_a   = 1'b1;
                m.alu_control = 3'b010;
                nxt           = ALUWB;
                case (m.funct)
                    6'b100000, 6'b100001: m.alu_control = 3'b010;
                    6'b100010, 6'b100011: m.alu_control = 3'b101;
                    6'b100100:            m.alu_control = 3'b000;
                    6'b100101:            m.alu_control = 3'b001;
                    6'b101010:            m.alu_control = 3'b111;
                    6'b000000:            nxt = FETCH;
                    default: begin
                        m.illegal = 1'b1;
                        nxt       = FETCH;
                    end
                endcase
            end
            ALUWB: begin
                m.reg_write = 1'b1;
                m.reg_dst   = 1'b1;
            end
            BRANCH: begin
                m.alu_src_a   = 1'b1;
                m.alu_control = 3'b110;
                m.pc_src      = 2'b01;
                m.pc_en       = m.zero;
            end
            IMMEXEC: begin
                m.alu_src_a   = 1'b1;
                m.alu_src_b   = 2'b10;
                m.zero_ext    = (m.op == OP_ORI) || (m.op == OP_LUI);
                m.alu_control = (m.op == OP_ORI) ? 3'b001 : (m.op == OP_LUI) ? 3'b011 : 3'b010;
                nxt           = IMMWB;
            end
            IMMWB: m.reg_write = 1'b1;
            JUMP: begin
                m.pc_src = 2'b10;
                m.pc_en  = 1'b1;
            end
            default: nxt = FETCH;
        endcase
        if (rst) begin
            m.pc_en     = 1'b0;
            m.ir_write  = 1'b0;
            m.mem_write = 1'b0;
            m.reg_write = 1'b0;
            m.illegal   = 1'b0;
        end
    end
endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 No parameters; all widths fixed.
REQ-002 clk  in  1  sole clock; all state changes on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 op  in  6  opcode field of instruction register (IR); stable from DECODE onward.
REQ-005 funct  in  6  function field of IR.
REQ-006 zero  in  1  ALU zero flag, same cycle.
REQ-007 mem_ready  in  1  memory handshake; port exists only with MCCTRL_MEMWAIT_EN.
REQ-008 pc_en  out  1  PC load enable.
REQ-009 ir_write  out  1  IR load enable.
REQ-010 iord  out  1  memory address: 0 = PC, 1 = ALU result register.
REQ-011 mem_write, reg_write  out  1 each  memory and register-file write strobes.
REQ-012 mem_to_reg, reg_dst  out  1 each  writeback data/destination selects (1 = memory data / rd).
REQ-013 alu_src_a  out  1  0 = PC, 1 = register A.
REQ-014 alu_src_b  out  2  00 = B, 01 = 4, 10 = extended imm, 11 = sign-ext imm<<2.
REQ-015 zero_ext  out  1  1 = zero-extend immediate (ori, lui).
REQ-016 pc_src  out  2  00 = ALU result, 01 = ALU result register, 10 = jump target.
REQ-017 alu_control  out  3  010 add, 110 sub (beq), 101 sub (subu/sub), 001 or, 000 and, 111 slt, 011 sll16 (lui).
REQ-018 state  out  4  current state code, debug.
REQ-019 illegal  out  1  one-cycle unsupported-instruction pulse.

Function
REQ-020 States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, IMMEXEC 9, IMMWB 10, JUMP 11; codes 12-15 unreachable and SHALL go to FETCH.
REQ-021 Outputs combinational from state (plus op/funct/zero/mem_ready as stated); unlisted strobes 0; selects default 0.
REQ-022 FETCH: iord 0, alu_src_a 0, alu_src_b 01, alu_control 010, pc_src 00, ir_write 1, pc_en 1; next DECODE.
REQ-023 DECODE: alu_src_a 0, alu_src_b 11, alu_control 010 (branch target precompute); next by op: lw/sw 100011/101011 -> MEMADR, R-type 000000 -> EXEC, beq 000100 -> BRANCH, addi 001000 / ori 001101 / lui 001111 -> IMMEXEC, j 000010 -> JUMP; any other op -> FETCH with illegal 1.
REQ-024 MEMADR: alu_src_a 1, alu_src_b 10, alu_control 010; next MEMRD if op = lw else MEMWR.
REQ-025 MEMRD: iord 1; next MEMWB. MEMWB: reg_write 1, mem_to_reg 1, reg_dst 0; next FETCH.
REQ-026 MEMWR: iord 1, mem_write 1; next FETCH.
REQ-027 EXEC: alu_src_a 1, alu_src_b 00, alu_control per funct: 100000/100001 -> 010, 100010/100011 -> 101, 100100 -> 000, 100101 -> 001, 101010 -> 111; next ALUWB.
REQ-028 EXEC with funct 000000 (nop): no illegal, next FETCH, no writeback; other unlisted funct: alu_control 010, illegal 1, next FETCH, no writeback.
REQ-029 ALUWB: reg_write 1, reg_dst 1, mem_to_reg 0; next FETCH.
REQ-030 BRANCH: alu_src_a 1, alu_src_b 00, alu_control 110, pc_src 01, pc_en = zero; next FETCH.
REQ-031 IMMEXEC: alu_src_a 1, alu_src_b 10; addi: 010, zero_ext 0; ori: 001, zero_ext 1; lui: 011, zero_ext 1; next IMMWB.
REQ-032 IMMWB: reg_write 1, reg_dst 0, mem_to_reg 0; next FETCH.
REQ-033 JUMP: pc_src 10, pc_en 1; next FETCH.
REQ-034 Cycle counts, no wait: lw 5, sw 4, R-type/imm 4, nop 3, beq 3, j 3, illegal op 2.

Reset
REQ-035 rst high at rising edge SHALL set state to FETCH, overriding any transition, including mid-instruction.
REQ-036 While rst is high, pc_en, ir_write, mem_write, reg_write, illegal SHALL be 0; other outputs show FETCH values.
REQ-037 First fetch strobes occur in the first cycle with rst low.

Configuration
REQ-038 MCCTRL_MEMWAIT_EN defined: mem_ready port present; FETCH, MEMRD, MEMWR hold state while mem_ready 0; in FETCH ir_write and pc_en assert only when mem_ready 1; mem_write held 1 throughout MEMWR; advance on first cycle with mem_ready 1.
REQ-039 MCCTRL_MEMWAIT_EN undefined: no mem_ready port; those states last exactly one cycle.

Verification
REQ-040 rst 1 two cycles, then lw (op 100011) -> states 0,1,2,3,4,0; reg_write + mem_to_reg only in state 4.
REQ-041 beq op 000100, zero 1 -> pc_en 1 in BRANCH; repeat with zero 0 -> pc_en 0; 3 cycles each.
REQ-042 R-type funct 100011 -> alu_control 101 in EXEC, ALUWB reg_dst 1; funct 000000 -> back to FETCH after EXEC, reg_write never 1.
REQ-043 op 111111 -> illegal 1 in DECODE only, next FETCH; lui -> alu_control 011, zero_ext 1.
REQ-044 rst asserted in MEMWR -> next state FETCH, mem_write 0 during reset cycle.
REQ-045 With MCCTRL_MEMWAIT_EN, sw with mem_ready low 3 cycles in MEMWR -> mem_write 1 for 4 cycles, then FETCH.
